sseg_scan_ctrl: RTL

Time-multiplexing controller for the 4-digit common-anode seven-segment display. It takes a 16-bit hex value plus per-digit blank and decimal-point masks. It scans one digit at a time with a non-overlapping guard gap between digits, and contains its own hex-to-segment decode. It sits between the user datapath (counters, ALU results) and the board display pins. Updates use a req/ack handshake and take effect only at frame boundaries, so no digit ever shows a torn value.

---
 rtl/sseg_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with guard gaps,
// built-in hex decode, leading-zero suppression and frame-aligned updates.
module sseg_scan_ctrl #(
  parameter int unsigned ON_CYCLES    = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        upd_req,
  input  logic [15:0] upd_val,
  input  logic [3:0]  upd_blank,
  input  logic [3:0]  upd_dp,
  input  logic        lz_en,
  output logic        upd_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned MAX_OG = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int unsigned MAXC   = (MAX_OG > 2) ? MAX_OG : 2;
  localparam int unsigned CW     = $clog2(MAXC);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  typedef enum logic [1:0] {IDLE, ON, GUARD} state_t;

  state_t        state, state_nx;
  logic [1:0]    digit, digit_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [15:0] pend_val, sh_val, eff_val;
  logic [3:0]  pend_blank, sh_blank, eff_blank;
  logic [3:0]  pend_dp, sh_dp, eff_dp;
  logic        pend_valid;
  logic        commit;
  logic [3:0]  lz_dark;
  logic [3:0]  nib;
  logic        dark;
  logic        frame_last;
  logic [3:0]  an_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h18;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ON;
      digit <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      digit <= digit_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    cnt_nx   = cnt;
    if (!enable) begin
      state_nx = IDLE;
      digit_nx = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ON;
          digit_nx = '0;
          cnt_nx   = '0;
        end
        ON: begin
          if (cnt == ON_LAST) begin
            cnt_nx = '0;
            if (GUARD_CYCLES == 0) digit_nx = digit + 2'd1;
            else                   state_nx = GUARD;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt_nx   = '0;
            state_nx = ON;
            digit_nx = digit + 2'd1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign commit = enable && (state == ON) && (digit == 2'd0) && (cnt == '0) && pend_valid;

  // On the commit cycle the shadow is still old, so display from pending to
  // keep the first cycle of the new frame untorn.
  assign eff_val   = commit ? pend_val   : sh_val;
  assign eff_blank = commit ? pend_blank : sh_blank;
  assign eff_dp    = commit ? pend_dp    : sh_dp;

  assign lz_dark[0] = 1'b0;
  assign lz_dark[1] = lz_en && (eff_val[15:4]  == '0);
  assign lz_dark[2] = lz_en && (eff_val[15:8]  == '0);
  assign lz_dark[3] = lz_en && (eff_val[15:12] == '0);

  assign nib  = eff_val[{digit, 2'b00} +: 4];
  assign dark = eff_blank[digit] | lz_dark[digit];

  assign frame_last = enable && (digit == 2'd3) &&
                      ((GUARD_CYCLES == 0) ? ((state == ON)    && (cnt == ON_LAST))
                                           : ((state == GUARD) && (cnt == GUARD_LAST)));

  always_comb begin
    an_nx  = 4'hF;
    seg_nx = 7'h7F;
    dp_nx  = 1'b1;
    if (enable && (state == ON)) begin
      an_nx = ~(4'b0001 << digit);
      if (!dark) begin
        seg_nx = hex_decode(nib);
        dp_nx  = ~eff_dp[digit];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_done <= frame_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_ack    <= 1'b0;
      pend_val   <= '0;
      pend_blank <= '1;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      sh_val     <= '0;
      sh_blank   <= '1;
      sh_dp      <= '0;
    end else begin
      upd_ack <= upd_req;
      if (upd_req) begin
        pend_val   <= upd_val;
        pend_blank <= upd_blank;
        pend_dp    <= upd_dp;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      if (commit) begin
        sh_val   <= pend_val;
        sh_blank <= pend_blank;
        sh_dp    <= pend_dp;
      end
    end
  end

endmodule
